// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: rotates a one-hot stage enable through NPHASE
// phases per instruction, counts retired instructions and handles halt/branch flush.
module phase_sequencer #(
    parameter int NPHASE = 5,
    parameter int CNTW   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_in,
    input  logic              pcsrc,
    output logic [NPHASE-1:0] phase,
    output logic              flush,
    output logic              running,
    output logic              halted,
    output logic [CNTW-1:0]   instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [NPHASE-1:0] PHASE_FIRST = {{(NPHASE-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0]   CNT_ONE     = {{(CNTW-1){1'b0}}, 1'b1};

    state_t            state_q, state_next;
    logic [NPHASE-1:0] phase_q, phase_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              flush_q, flush_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;
    logic [NPHASE-1:0] phase_rot;
    logic              last_phase;

    assign phase_rot  = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
    assign last_phase = phase_q[NPHASE-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            count_q   <= '0;
            flush_q   <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_next;
            phase_q   <= phase_d;
            count_q   <= count_d;
            flush_q   <= flush_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    // A halt request only takes effect at the un-stalled last phase of an instruction.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (!stall && last_phase && halt_in) state_next = HALT;
            HALT:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                phase_d = '0;
                if (start) begin
                    phase_d = PHASE_FIRST;
                    count_d = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (last_phase) begin
                        count_d = count_q + CNT_ONE;
                        if (halt_in) begin
                            phase_d = '0;
                        end else begin
                            phase_d = phase_rot;
                            flush_d = pcsrc;
                        end
                    end else begin
                        phase_d = phase_rot;
                    end
                end
            end
            default: begin
                phase_d = '0;
                count_d = '0;
            end
        endcase
        running_d = (state_next == RUN);
        halted_d  = (state_next == HALT);
    end

    assign phase       = phase_q;
    assign flush       = flush_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
